// File: rtl/adaptive_threshold_seq.sv
// Frame sequencer and threshold stage: launches the box filter, then raster-scans image + threshold.
// Optional box-filter watchdog (oTimeout) is enabled by defining ADAPTIVE_THRESHOLD_WATCHDOG_EN.
module adaptive_threshold_seq #(
    parameter int unsigned WIDTH_BITS     = 8,
    parameter int unsigned HEIGHT_BITS    = 8,
    parameter int unsigned COLOR_BITS     = 3,
    parameter int unsigned FRAME_CNT_BITS = 16
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iStart,
    input  logic                      iContinuous,
    input  logic [7:0]                iOffset,
    input  logic                      iInvert,
    output logic                      oBusy,
    output logic                      oDone,
    output logic [FRAME_CNT_BITS-1:0] oFrameCount,
    output logic                      oBoxStart,
    input  logic                      iBoxFinished,
    input  logic [WIDTH_BITS-1:0]     iBoxImageCol,
    input  logic [HEIGHT_BITS-1:0]    iBoxImageRow,
    output logic [WIDTH_BITS-1:0]     oImageCol,
    output logic [HEIGHT_BITS-1:0]    oImageRow,
    input  logic [7:0]                iImageData,
    output logic [WIDTH_BITS-1:0]     oThrCol,
    output logic [HEIGHT_BITS-1:0]    oThrRow,
    input  logic [7:0]                iThrData,
    output logic                      oValid,
    output logic [WIDTH_BITS-1:0]     oX,
    output logic [HEIGHT_BITS-1:0]    oY,
    output logic [COLOR_BITS-1:0]     oR,
    output logic [COLOR_BITS-1:0]     oG,
    output logic [COLOR_BITS-1:0]     oB
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    ,
    output logic                      oTimeout
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StBoxStart,
        StBoxRun,
        StThrRun,
        StThrDrain,
        StDone
    } state_e;

    localparam logic [WIDTH_BITS-1:0]  ColMax = '1;
    localparam logic [HEIGHT_BITS-1:0] RowMax = '1;

    state_e state_q, state_d;

    logic [WIDTH_BITS-1:0]     col_q, col_d;
    logic [HEIGHT_BITS-1:0]    row_q, row_d;
    logic [7:0]                offset_q, offset_d;
    logic                      invert_q, invert_d;
    logic                      box_first_q, box_first_d;
    logic                      drain_q, drain_d;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;

    // Stage 1: address issued last cycle, ROM/RAM data arriving this cycle.
    logic                      p1_valid_q, p1_valid_d;
    logic [WIDTH_BITS-1:0]     p1_x_q, p1_x_d;
    logic [HEIGHT_BITS-1:0]    p1_y_q, p1_y_d;

    // Stage 2: registered pixel output.
    logic                      valid_q, valid_d;
    logic [WIDTH_BITS-1:0]     x_q, x_d;
    logic [HEIGHT_BITS-1:0]    y_q, y_d;
    logic [COLOR_BITS-1:0]     rgb_q, rgb_d;

    logic [7:0]                eff;
    logic                      pix_bit;
    logic                      box_phase;
    logic                      last_addr;

`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    localparam int unsigned WdBits = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WdBits-1:0] wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;
    logic              wd_expired;

    assign wd_expired = (wd_cnt_q == WdBits'(TIMEOUT_CYCLES - 1));
    assign oTimeout   = timeout_q;
`endif

    assign box_phase = (state_q == StBoxStart) || (state_q == StBoxRun);
    assign last_addr = (col_q == ColMax) && (row_q == RowMax);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (iStart) state_d = StBoxStart;
            end
            StBoxStart: begin
                state_d = StBoxRun;
            end
            StBoxRun: begin
                // The finished level is stale from the previous frame on the first cycle.
                if (!box_first_q && iBoxFinished) begin
                    state_d = StThrRun;
                end
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d = StIdle;
                end
`endif
            end
            StThrRun: begin
                if (last_addr) state_d = StThrDrain;
            end
            StThrDrain: begin
                if (drain_q) state_d = StDone;
            end
            StDone: begin
                state_d = iContinuous ? StBoxStart : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scan counters, per-frame latches and frame counter.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        offset_d    = offset_q;
        invert_d    = invert_q;
        frame_cnt_d = frame_cnt_q;
        box_first_d = (state_q == StBoxStart);
        drain_d     = (state_q == StThrDrain) ? ~drain_q : 1'b0;

        if (state_q == StBoxStart) begin
            col_d    = '0;
            row_d    = '0;
            offset_d = iOffset;
            invert_d = iInvert;
        end else if (state_q == StThrRun) begin
            col_d = col_q + WIDTH_BITS'(1);
            if (col_q == ColMax) row_d = row_q + HEIGHT_BITS'(1);
        end

        if (state_q == StDone) frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
    end

`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    always_comb begin
        wd_cnt_d  = (state_q == StBoxRun) ? wd_cnt_q + WdBits'(1) : '0;
        timeout_d = timeout_q;
        if (state_q == StIdle && iStart) begin
            timeout_d = 1'b0;
        end else if (state_q == StBoxRun && state_d == StIdle) begin
            timeout_d = 1'b1;
        end
    end
`endif

    // Threshold arithmetic: saturating subtract, compare, optional invert.
    always_comb begin
        eff     = (iThrData >= offset_q) ? (iThrData - offset_q) : 8'd0;
        pix_bit = (iImageData > eff) ^ invert_q;
    end

    // Two-stage pixel pipeline.
    always_comb begin
        p1_valid_d = (state_q == StThrRun);
        p1_x_d     = col_q;
        p1_y_d     = row_q;
        valid_d    = p1_valid_q;
        x_d        = x_q;
        y_d        = y_q;
        rgb_d      = '0;
        if (p1_valid_q) begin
            x_d   = p1_x_q;
            y_d   = p1_y_q;
            rgb_d = {COLOR_BITS{pix_bit}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            offset_q    <= '0;
            invert_q    <= 1'b0;
            box_first_q <= 1'b0;
            drain_q     <= 1'b0;
            frame_cnt_q <= '0;
            p1_valid_q  <= 1'b0;
            p1_x_q      <= '0;
            p1_y_q      <= '0;
            valid_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            offset_q    <= offset_d;
            invert_q    <= invert_d;
            box_first_q <= box_first_d;
            drain_q     <= drain_d;
            frame_cnt_q <= frame_cnt_d;
            p1_valid_q  <= p1_valid_d;
            p1_x_q      <= p1_x_d;
            p1_y_q      <= p1_y_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rgb_q       <= rgb_d;
        end
    end

`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // The shared ROM belongs to the box filter until it reports finished.
    assign oImageCol = box_phase ? iBoxImageCol : col_q;
    assign oImageRow = box_phase ? iBoxImageRow : row_q;
    assign oThrCol   = col_q;
    assign oThrRow   = row_q;

    assign oBusy       = (state_q != StIdle);
    assign oDone       = (state_q == StDone);
    assign oBoxStart   = (state_q == StBoxStart);
    assign oFrameCount = frame_cnt_q;
    assign oValid      = valid_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oR          = rgb_q;
    assign oG          = rgb_q;
    assign oB          = rgb_q;

endmodule

// File: tb/tb_adaptive_threshold_seq.sv
// Bench for adaptive_threshold_seq: table of uniform frames plus multi-cycle corner sequences.
// Watchdog checks are compiled in when ADAPTIVE_THRESHOLD_WATCHDOG_EN is defined.
module tb_adaptive_threshold_seq;

    localparam int unsigned WB   = 2;
    localparam int unsigned HB   = 2;
    localparam int unsigned CB   = 3;
    localparam int unsigned FB   = 16;
    localparam int          NPIX = 16;
    localparam int          BOX_DELAY = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, iStart, iContinuous, iInvert, iBoxFinished;
    logic [7:0]    iOffset, iImageData, iThrData;
    logic          oBusy, oDone, oBoxStart, oValid;
    logic [FB-1:0] oFrameCount;
    logic [WB-1:0] iBoxImageCol, oImageCol, oThrCol, oX;
    logic [HB-1:0] iBoxImageRow, oImageRow, oThrRow, oY;
    logic [CB-1:0] oR, oG, oB;
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
    logic          oTimeout;
`endif

    adaptive_threshold_seq #(
        .WIDTH_BITS    (WB),
        .HEIGHT_BITS   (HB),
        .COLOR_BITS    (CB),
        .FRAME_CNT_BITS(FB)
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES(32)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iStart      (iStart),
        .iContinuous (iContinuous),
        .iOffset     (iOffset),
        .iInvert     (iInvert),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oFrameCount (oFrameCount),
        .oBoxStart   (oBoxStart),
        .iBoxFinished(iBoxFinished),
        .iBoxImageCol(iBoxImageCol),
        .iBoxImageRow(iBoxImageRow),
        .oImageCol   (oImageCol),
        .oImageRow   (oImageRow),
        .iImageData  (iImageData),
        .oThrCol     (oThrCol),
        .oThrRow     (oThrRow),
        .iThrData    (iThrData),
        .oValid      (oValid),
        .oX          (oX),
        .oY          (oY),
        .oR          (oR),
        .oG          (oG),
        .oB          (oB)
`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
        ,
        .oTimeout    (oTimeout)
`endif
    );

    // Memory and box-filter models.
    logic [7:0] pix_mem [NPIX];
    logic [7:0] thr_mem [NPIX];
    logic       box_finished, box_active, box_stuck, box_never;
    int         box_cnt;

    always_ff @(posedge clock) begin
        iImageData <= pix_mem[{oImageRow, oImageCol}];
        iThrData   <= thr_mem[{oThrRow, oThrCol}];
    end

    // Finished is a level that drops one cycle after the start pulse, so it is stale at first.
    always_ff @(posedge clock) begin
        if (reset) begin
            box_finished <= 1'b0;
            box_active   <= 1'b0;
            box_cnt      <= 0;
        end else if (oBoxStart) begin
            box_active <= 1'b1;
            box_cnt    <= 0;
        end else if (box_active) begin
            box_cnt <= box_cnt + 1;
            if (box_cnt == 0) box_finished <= 1'b0;
            if (box_cnt == BOX_DELAY) begin
                box_finished <= 1'b1;
                box_active   <= 1'b0;
            end
        end
    end

    always_comb iBoxFinished = box_stuck | (box_finished & ~box_never);

    // Scoreboard and counters.
    typedef struct packed {
        logic [WB-1:0] x;
        logic [HB-1:0] y;
        logic [CB-1:0] rgb;
    } exp_t;

    typedef struct packed {
        logic [7:0] pix;
        logic [7:0] thr;
        logic [7:0] off;
        logic       inv;
        logic [2:0] rgb;
    } vec_t;

    exp_t sb[$];
    vec_t vecs [9];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, start_cyc = 0, lat = 0;
    int box_starts = 0, dones = 0, valid_cnt = 0, valid_rises = 0;
    int b0, d0, v0, r0;
    int exp_frames = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (oBoxStart) begin
            box_starts++;
            start_cyc = cyc;
        end
        if (oDone) dones++;
        if (oValid) begin
            valid_cnt++;
            if (!prev_valid) begin
                valid_rises++;
                lat = cyc - start_cyc;
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got pixel (%0d,%0d), expected none", oX, oY);
            end else begin
                e = sb.pop_front();
                chk("pix_x", 32'(oX), 32'(e.x));
                chk("pix_y", 32'(oY), 32'(e.y));
                chk("pix_r", 32'(oR), 32'(e.rgb));
                chk("pix_g", 32'(oG), 32'(e.rgb));
                chk("pix_b", 32'(oB), 32'(e.rgb));
            end
        end else begin
            chk("rgb_idle_zero", 32'({oR, oG, oB}), 0);
        end
        prev_valid = oValid;
    end

    function automatic logic model_bit(input logic [7:0] p, input logic [7:0] t,
                                       input logic [7:0] o, input logic inv);
        logic [7:0] e;
        e = (t >= o) ? t - o : 8'd0;
        return (p > e) ^ inv;
    endfunction

    task automatic push_uniform(input logic [7:0] p, input logic [7:0] t, input logic [2:0] rgb,
                                input int frames);
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            pix_mem[i] = p;
            thr_mem[i] = t;
        end
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                e.x   = WB'(i % 4);
                e.y   = HB'(i / 4);
                e.rgb = rgb;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] off, input logic inv);
        b0 = box_starts;
        d0 = dones;
        v0 = valid_cnt;
        r0 = valid_rises;
        iOffset = off;
        iInvert = inv;
        iStart  = 1'b1;
        @(negedge clock);
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clock);
            seen = oDone;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no oDone, expected oDone within 300 cycles", tag);
        end
    endtask

    task automatic finish_frame(input string tag, input int exp_lat);
        wait_done(tag);
        @(negedge clock);
        exp_frames++;
        chk({tag, "_box_starts"}, box_starts - b0, 1);
        chk({tag, "_dones"}, dones - d0, 1);
        chk({tag, "_valid_cnt"}, valid_cnt - v0, NPIX);
        chk({tag, "_contiguous"}, valid_rises - r0, 1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_frame_cnt"}, 32'(oFrameCount), exp_frames);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_busy"}, 32'(oBusy), 0);
        chk({tag, "_x_hold"}, 32'(oX), 3);
        chk({tag, "_y_hold"}, 32'(oY), 3);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] off;
        exp_t e;
        int   n;

        vecs[0] = '{8'd100, 8'd90, 8'd0, 1'b0, 3'd7};
        vecs[1] = '{8'd0, 8'd5, 8'd20, 1'b0, 3'd0};
        vecs[2] = '{8'd1, 8'd5, 8'd20, 1'b0, 3'd7};
        vecs[3] = '{8'd50, 8'd50, 8'd0, 1'b1, 3'd7};
        vecs[4] = '{8'd50, 8'd50, 8'd0, 1'b0, 3'd0};
        vecs[5] = '{8'd60, 8'd70, 8'd10, 1'b0, 3'd0};
        vecs[6] = '{8'd61, 8'd70, 8'd10, 1'b0, 3'd7};
        vecs[7] = '{8'd255, 8'd255, 8'd255, 1'b1, 3'd0};
        vecs[8] = '{8'd200, 8'd10, 8'd11, 1'b1, 3'd0};

        reset = 1'b1; iStart = 1'b0; iContinuous = 1'b0; iInvert = 1'b0; iOffset = 8'd0;
        iBoxImageCol = '0; iBoxImageRow = '0; box_stuck = 1'b0; box_never = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            pix_mem[i] = 8'd0;
            thr_mem[i] = 8'd0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_box_start", 32'(oBoxStart), 0);
        chk("rst_frame_cnt", 32'(oFrameCount), 0);
        chk("rst_xy", 32'({oX, oY}), 0);
        chk("rst_rgb", 32'({oR, oG, oB}), 0);

        for (int v = 0; v < 9; v++) begin
            push_uniform(vecs[v].pix, vecs[v].thr, vecs[v].rgb, 1);
            start_frame(vecs[v].off, vecs[v].inv);
            finish_frame($sformatf("vec%0d", v), 15);
        end

        // Random image against the arithmetic model.
        off = 8'($urandom_range(0, 40));
        for (int i = 0; i < NPIX; i++) begin
            pix_mem[i] = 8'($urandom_range(0, 255));
            thr_mem[i] = 8'($urandom_range(0, 255));
            e.x   = WB'(i % 4);
            e.y   = HB'(i / 4);
            e.rgb = {CB{model_bit(pix_mem[i], thr_mem[i], off, 1'b0)}};
            sb.push_back(e);
        end
        start_frame(off, 1'b0);
        finish_frame("random", 15);

        // Offset and invert are latched per frame; changes mid-frame must not leak in.
        push_uniform(8'd50, 8'd50, 3'd0, 1);
        start_frame(8'd0, 1'b0);
        repeat (20) @(negedge clock);
        iInvert = 1'b1;
        iOffset = 8'd40;
        finish_frame("inv_mid", 15);
        push_uniform(8'd50, 8'd50, 3'd7, 1);
        start_frame(8'd0, 1'b1);
        finish_frame("inv_next", 15);

        // Continuous mode with iStart held high throughout the first two frames.
        push_uniform(8'd100, 8'd90, 3'd7, 3);
        b0 = box_starts; d0 = dones; v0 = valid_cnt; r0 = valid_rises;
        iOffset = 8'd0; iInvert = 1'b0; iContinuous = 1'b1; iStart = 1'b1;
        @(negedge clock);
        wait_done("cont1");
        @(negedge clock);
        chk("cont1_restart", 32'(oBoxStart), 1);
        wait_done("cont2");
        @(negedge clock);
        chk("cont2_restart", 32'(oBoxStart), 1);
        iContinuous = 1'b0;
        iStart = 1'b0;
        wait_done("cont3");
        @(negedge clock);
        exp_frames += 3;
        chk("cont_idle", 32'(oBusy), 0);
        chk("cont_box_starts", box_starts - b0, 3);
        chk("cont_dones", dones - d0, 3);
        chk("cont_valid_cnt", valid_cnt - v0, 3 * NPIX);
        chk("cont_frame_cnt", 32'(oFrameCount), exp_frames);
        chk("cont_sb_empty", sb.size(), 0);

        // Finished stuck high: first BOX_RUN cycle must not advance; ROM belongs to the box filter.
        box_stuck = 1'b1;
        iBoxImageCol = 2'd2;
        iBoxImageRow = 2'd1;
        push_uniform(8'd100, 8'd90, 3'd7, 1);
        start_frame(8'd0, 1'b0);
        chk("mux_col", 32'(oImageCol), 2);
        chk("mux_row", 32'(oImageRow), 1);
        finish_frame("stale", 5);
        box_stuck = 1'b0;

        // Reset while the scan is addressing pixel 7.
        push_uniform(8'd100, 8'd90, 3'd7, 1);
        start_frame(8'd0, 1'b0);
        n = 0;
        while (!(oBusy && oThrRow == 2'd1 && oThrCol == 2'd3) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("rst_mid_reach_px7", n < 100, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_valid", 32'(oValid), 0);
        chk("rst_mid_busy", 32'(oBusy), 0);
        chk("rst_mid_done", 32'(oDone), 0);
        chk("rst_mid_frame_cnt", 32'(oFrameCount), 0);
        reset = 1'b0;
        sb.delete();
        exp_frames = 0;
        repeat (5) @(negedge clock);
        chk("rst_mid_no_done", dones - d0, 0);
        chk("rst_mid_idle", 32'(oBusy), 0);

`ifdef ADAPTIVE_THRESHOLD_WATCHDOG_EN
        box_never = 1'b1;
        start_frame(8'd0, 1'b0);
        n = 0;
        while (oBusy && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wd_cycles", n, 33);
        chk("wd_timeout", 32'(oTimeout), 1);
        chk("wd_no_done", dones - d0, 0);
        chk("wd_frame_cnt", 32'(oFrameCount), exp_frames);
        box_never = 1'b0;
        push_uniform(8'd100, 8'd90, 3'd7, 1);
        start_frame(8'd0, 1'b0);
        chk("wd_clear", 32'(oTimeout), 0);
        finish_frame("wd_after", 15);
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adaptive_threshold_seq.md
Name: adaptive_threshold_seq

Overview:
Parametrised frame sequencer and threshold stage for the adaptive-thresholding pipeline. It replaces the fixed start/finish glue between the box filter and the threshold pass. It launches the external box filter, arbitrates the shared image ROM address, then raster-scans the image and the threshold RAM itself. For each pixel it emits a binarised value with valid, offset, invert and continuous-frame modes.

Parameters:
WIDTH_BITS, 8, column address width; image width = 2**WIDTH_BITS
HEIGHT_BITS, 8, row address width; image height = 2**HEIGHT_BITS
COLOR_BITS, 3, bits per output colour channel
FRAME_CNT_BITS, 16, width of completed-frame counter
TIMEOUT_CYCLES, 2**20, watchdog limit on BOX_RUN (used only with the optional feature)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
iStart  in  1  start request; sampled in IDLE only
iContinuous  in  1  1: restart automatically after DONE
iOffset  in  8  constant subtracted from the local mean (latched per frame)
iInvert  in  1  1: invert the binary result (latched per frame)
oBusy  out  1  high in every state except IDLE
oDone  out  1  one-cycle pulse per completed frame
oFrameCount  out  FRAME_CNT_BITS  completed frames, wraps
oBoxStart  out  1  one-cycle start pulse to the box filter
iBoxFinished  in  1  box filter finished level
iBoxImageCol / iBoxImageRow  in  WIDTH_BITS / HEIGHT_BITS  box filter ROM address
oImageCol / oImageRow  out  WIDTH_BITS / HEIGHT_BITS  shared image ROM address
iImageData  in  8  ROM data, 1-cycle read latency
oThrCol / oThrRow  out  WIDTH_BITS / HEIGHT_BITS  threshold RAM read address
iThrData  in  8  threshold RAM data, 1-cycle latency
oValid  out  1  pixel output valid
oX / oY  out  WIDTH_BITS / HEIGHT_BITS  coordinate of output pixel
oR / oG / oB  out  COLOR_BITS  result replicated across all bits

Behaviour:
- Reset: state IDLE; scan counters, oValid, oDone, oBoxStart, oX, oY, oR/oG/oB, oFrameCount all 0. Reset mid-frame aborts at once, with no oDone.
- States: IDLE -> BOX_START -> BOX_RUN -> THR_RUN -> THR_DRAIN -> DONE.
- IDLE: on iStart=1 go to BOX_START. iStart in any other state is ignored.
- BOX_START (1 cycle): oBoxStart=1; latch iOffset and iInvert; clear scan counters.
- BOX_RUN: ignore iBoxFinished in the first BOX_RUN cycle, because finished is stale from the previous frame. From the second cycle on, iBoxFinished=1 moves to THR_RUN.
- ROM address mux: in BOX_START/BOX_RUN, oImageCol/Row pass through iBoxImageCol/Row combinationally. Otherwise they follow the scan counters.
- THR_RUN: each cycle present (col,row) on both oImage* and oThr*. Col increments; on col wrap, row increments. After address (max,max) go to THR_DRAIN. One pixel per cycle; no stalls.
- Pipeline: address at cycle t, data at t+1, registered output at t+2. oX/oY carry the delayed address.
- Arithmetic: eff = (iThrData >= offset) ? iThrData - offset : 0, an 8-bit unsigned saturating subtract. bit = (iImageData > eff) XOR invert.
- Outputs: oR=oG=oB={COLOR_BITS{bit}} while oValid=1, and forced 0 when oValid=0. oX/oY hold their last value while invalid.
- THR_DRAIN: 2 cycles, flushing the final two pixels, then DONE.
- DONE (1 cycle): oDone=1 and oFrameCount+1, wrapping to 0 at all-ones. Next state is BOX_START if iContinuous=1, else IDLE. iContinuous is sampled in this cycle.
- Exactly 2**(WIDTH_BITS+HEIGHT_BITS) oValid cycles per frame, contiguous, in raster order.

Optional Feature:
ADAPTIVE_THRESHOLD_WATCHDOG_EN
- Defined: adds output oTimeout (1 bit, sticky) and a BOX_RUN cycle counter. If the counter reaches TIMEOUT_CYCLES without iBoxFinished, the block goes to IDLE, sets oTimeout, and does not pulse oDone. oTimeout clears on reset or on the next accepted iStart.
- Undefined: no port and no counter; BOX_RUN waits indefinitely.

Test Plan:
- WIDTH_BITS=HEIGHT_BITS=2. Reset, iStart pulse, box filter model finishes after 10 cycles, ROM pixel=100, thr=90, offset=0 -> oBoxStart pulses once; 16 contiguous oValid cycles in raster order (0,0)..(3,3); RGB=7; single oDone; oFrameCount=1.
- Offset saturation: thr=5, offset=20, pixel=0 -> eff=0, bit=0, RGB=0. Pixel=1 -> RGB=7.
- Invert=1 with pixel=thr=50 -> bit=1, RGB=7. Change iInvert mid-frame -> no effect until the next frame.
- iContinuous=1 for 3 frames with iStart held -> oDone pulses 3 times; BOX_START follows DONE directly; oFrameCount=3; iStart is ignored while busy.
- iBoxFinished held high from the previous frame -> first BOX_RUN cycle does not advance. Assert reset during THR_RUN at pixel 7 -> next cycle oValid=0, oBusy=0, no oDone.
- With ADAPTIVE_THRESHOLD_WATCHDOG_EN and TIMEOUT_CYCLES=32, iBoxFinished never rises -> oTimeout=1 after 32 BOX_RUN cycles; IDLE; oFrameCount unchanged.
